// File: rtl/fifo_lib_pkg.sv
// Shared types for the FIFO stream reader: state encoding of the two-entry
// output stage (main register plus skid register).
package fifo_lib_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } out_state_e;

endpackage : fifo_lib_pkg

// File: rtl/fifo_stream_reader_if.sv
// Bundle of the reader's FIFO read port and stream port. The master modport is
// the reader's view; the slave modport is the FIFO/stream-sink environment.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output fifo_rd,
        input  fifo_rd_data,
        input  fifo_empty,
        output tdata,
        output tvalid,
        input  tready,
        output tlast
    );

    modport slave (
        input  fifo_rd,
        output fifo_rd_data,
        output fifo_empty,
        input  tdata,
        input  tvalid,
        output tready,
        input  tlast
    );
endinterface : fifo_stream_reader_if

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO into a valid/ready stream through a 2-entry output stage.
// Define FIFO_STREAM_READER_TLAST_EN to frame the stream into PKT_LEN-beat packets via tlast_o.
module fifo_stream_reader
    import fifo_lib_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 16,
    parameter int CNT_WIDTH  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    output logic                  fifo_rd_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_empty_i,
    output logic [DATA_WIDTH-1:0] tdata_o,
    output logic                  tvalid_o,
    input  logic                  tready_i,
    output logic                  tlast_o
);

    if (PKT_LEN < 1 || CNT_WIDTH < 1 || (2 ** CNT_WIDTH) < PKT_LEN) begin : g_bad_cfg
        $error("fifo_stream_reader: PKT_LEN must be >= 1 and fit in CNT_WIDTH bits");
    end

    out_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  tvalid_q;
    logic                  pop_s;

    // Popping depends only on held state, never on tready_i, so the FIFO read
    // strobe has no combinational path from the stream sink.
    assign pop_s     = !fifo_empty_i && (state_q != TWO) && !flush_i && !rst_i;
    assign fifo_rd_o = pop_s;

    // Output-stage next state: flush wins over any pop or handshake
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (pop_s) begin
                        main_d  = fifo_rd_data_i;
                        state_d = ONE;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (pop_s && tready_i) begin
                        main_d  = fifo_rd_data_i;
                        state_d = ONE;
                    end else if (pop_s) begin
                        skid_d  = fifo_rd_data_i;
                        state_d = TWO;
                    end else if (tready_i) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                TWO: begin
                    if (tready_i) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end else begin
                        state_d = TWO;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Output-stage registers; tvalid is registered from the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= EMPTY;
            main_q   <= {DATA_WIDTH{1'b0}};
            skid_q   <= {DATA_WIDTH{1'b0}};
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            tvalid_q <= (state_d != EMPTY);
        end
    end

    assign tdata_o  = main_q;
    assign tvalid_o = tvalid_q;

`ifdef FIFO_STREAM_READER_TLAST_EN
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PKT_LEN - 1);

    logic                 hs_s;
    logic [CNT_WIDTH-1:0] beat_q, beat_d;
    logic                 tlast_q;

    assign hs_s = tvalid_q && tready_i;

    // beat_q is the packet index of the word currently sitting in main
    always_comb begin
        beat_d = beat_q;
        if (flush_i) begin
            beat_d = {CNT_WIDTH{1'b0}};
        end else if (hs_s) begin
            if (beat_q == LAST_BEAT) begin
                beat_d = {CNT_WIDTH{1'b0}};
            end else begin
                beat_d = beat_q + CNT_WIDTH'(1);
            end
        end else begin
            beat_d = beat_q;
        end
    end

    // Beat counter and registered tlast
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q  <= {CNT_WIDTH{1'b0}};
            tlast_q <= 1'b0;
        end else begin
            beat_q  <= beat_d;
            tlast_q <= (state_d != EMPTY) && (beat_d == LAST_BEAT);
        end
    end

    assign tlast_o = tlast_q;
`else
    assign tlast_o = 1'b0;
`endif

endmodule : fifo_stream_reader

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: FIFO word and stream data width.
REQ-002 SHALL have parameter PKT_LEN, default 16: beats per packet for tlast framing, legal range >= 1.
REQ-003 SHALL have parameter CNT_WIDTH, default max(1, $clog2(PKT_LEN)): beat counter width.
REQ-004 SHALL have port clk_i, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port flush_i, input, 1: synchronous discard of held words and framing state.
REQ-007 SHALL have port fifo_rd_o, output, 1: pop strobe to the sc_fifo read port.
REQ-008 SHALL have port fifo_rd_data_i, input, DATA_WIDTH: show-ahead FIFO head word, valid while fifo_empty_i is 0.
REQ-009 SHALL have port fifo_empty_i, input, 1: FIFO empty flag.
REQ-010 SHALL have port tdata_o, output, DATA_WIDTH: stream data.
REQ-011 SHALL have port tvalid_o, output, 1: stream valid.
REQ-012 SHALL have port tready_i, input, 1: stream ready.
REQ-013 SHALL have port tlast_o, output, 1: last beat of packet.

Function
REQ-014 SHALL drive fifo_rd_o = !fifo_empty_i && !skid_valid && !flush_i, with no combinational path from tready_i.
REQ-015 SHALL capture fifo_rd_data_i in the cycle fifo_rd_o is 1, because FIFO data is show-ahead.
REQ-016 SHALL implement a 2-entry output stage (main, skid) with states EMPTY, ONE, TWO.
REQ-017 SHALL, in EMPTY on pop, load main and go to ONE.
REQ-018 SHALL, in ONE on pop and tready_i, load main and stay in ONE.
REQ-019 SHALL, in ONE on pop and !tready_i, load skid and go to TWO.
REQ-020 SHALL, in ONE with no pop and tready_i, go to EMPTY.
REQ-021 SHALL, in TWO on tready_i, move skid to main and go to ONE; no pop occurs in TWO.
REQ-022 SHALL drive tvalid_o = (state != EMPTY) and tdata_o = main, both registered.
REQ-023 SHALL hold tdata_o, tvalid_o and tlast_o stable while tvalid_o && !tready_i.
REQ-024 SHALL sustain 1 beat/clock when the FIFO is non-empty and tready_i is held 1.
REQ-025 SHALL have 1 cycle latency from the first pop to tvalid_o = 1.
REQ-026 SHALL never lose or duplicate a word, including when tready_i toggles every cycle.
REQ-027 SHALL, when flush_i = 1, go to EMPTY on the next edge and clear the beat counter; flush has priority over pop and handshake.

Reset
REQ-028 SHALL, on rst_i, set state EMPTY, tvalid_o 0, tlast_o 0, tdata_o 0 and the beat counter 0.
REQ-029 SHALL hold fifo_rd_o at 0 during reset; a reset asserted mid-packet discards held words and restarts framing at beat 0.

Configuration
REQ-030 SHALL use macro FIFO_STREAM_READER_TLAST_EN to control packet framing.
REQ-031 SHALL, with the macro defined, count handshakes (tvalid_o && tready_i) modulo PKT_LEN.
REQ-032 SHALL, with the macro defined, set tlast_o = 1 when the beat in main is beat index PKT_LEN-1; with PKT_LEN = 1 every beat is last.
REQ-033 SHALL, with the macro undefined, tie tlast_o to 0 and instantiate no counter logic.

Structure
REQ-034 SHALL place the output-stage state enum (EMPTY, ONE, TWO) in shared package fifo_lib_pkg.
REQ-035 SHALL be a single module with no sub-module; the output stage and counter are too small to split.

Verification
REQ-036 SHALL verify: DATA_WIDTH 8, FIFO holds 0x01..0x04, tready_i = 1 -> 4 pops on consecutive cycles; tdata_o 0x01..0x04 on consecutive cycles starting 1 cycle after the first pop.
REQ-037 SHALL verify: FIFO holds 0xA0..0xA2, tready_i = 0 -> 2 pops, then fifo_rd_o stays 0; tdata_o holds 0xA0; after tready_i = 1, output is 0xA0, 0xA1, 0xA2 in order.
REQ-038 SHALL verify: random tready_i (50%) and random FIFO fill, 1000 words -> output sequence identical to input sequence, no drop or duplicate.
REQ-039 SHALL verify: macro defined, PKT_LEN 4, 12 beats -> tlast_o = 1 on beats 4, 8 and 12 only.
REQ-040 SHALL verify: macro defined, flush_i pulsed after beat 2 of a PKT_LEN 4 packet while state is TWO -> tvalid_o 0 next cycle; the next beat accepted is counted as beat 1 and tlast_o asserts on the 4th beat after the flush.
REQ-041 SHALL verify: rst_i asserted while state is TWO -> tvalid_o 0 and fifo_rd_o 0 during reset; normal streaming resumes 1 cycle after reset release.
